// File: rtl/fetch_inst_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {inst, pc, seq_num}
// with valid/ready handshakes on both sides and a single-cycle squash flush.
module fetch_inst_queue #(
   parameter int p_seq_num_bits = 5,
   parameter int p_depth        = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_val,
   output logic                       in_rdy,
   input  logic [31:0]                in_inst,
   input  logic [31:0]                in_pc,
   input  logic [p_seq_num_bits-1:0]  in_seq_num,
   output logic                       out_val,
   input  logic                       out_rdy,
   output logic [31:0]                out_inst,
   output logic [31:0]                out_pc,
   output logic [p_seq_num_bits-1:0]  out_seq_num,
   input  logic                       squash_val,
   output logic [$clog2(p_depth):0]   count
);

   localparam int ptr_w = $clog2(p_depth);
   localparam int cnt_w = ptr_w + 1;

   typedef struct packed {
      logic [31:0]               inst;
      logic [31:0]               pc;
      logic [p_seq_num_bits-1:0] seq_num;
   } entry_t;

   entry_t             mem_q [p_depth];
   logic [ptr_w-1:0]   head_q, head_d;
   logic [ptr_w-1:0]   tail_q, tail_d;
   logic [cnt_w-1:0]   count_q, count_d;
   logic               in_xfer;
   logic               out_xfer;

   // Full-queue backpressure ignores out_rdy so in_rdy never depends on decode.
   always_comb begin
      in_rdy   = (count_q < cnt_w'(p_depth)) & ~squash_val;
      out_val  = (count_q != '0) & ~squash_val;
      in_xfer  = in_val & in_rdy;
      out_xfer = out_val & out_rdy;

      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;

      if (squash_val) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (in_xfer)  tail_d = tail_q + ptr_w'(1);
         if (out_xfer) head_d = head_q + ptr_w'(1);
         if (in_xfer && !out_xfer)      count_d = count_q + cnt_w'(1);
         else if (out_xfer && !in_xfer) count_d = count_q - cnt_w'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage is deliberately left out of reset; only pointers define validity.
   always_ff @(posedge clk) begin
      if (in_xfer && !rst) begin
         mem_q[tail_q] <= '{inst: in_inst, pc: in_pc, seq_num: in_seq_num};
      end
   end

   assign out_inst    = mem_q[head_q].inst;
   assign out_pc      = mem_q[head_q].pc;
   assign out_seq_num = mem_q[head_q].seq_num;
   assign count       = count_q;

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Directed-vector and reference-model bench for fetch_inst_queue (depth 4).
module tb_fetch_inst_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_val;
   logic        in_rdy;
   logic [31:0] in_inst;
   logic [31:0] in_pc;
   logic [4:0]  in_seq_num;
   logic        out_val;
   logic        out_rdy;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic [4:0]  out_seq_num;
   logic        squash_val;
   logic [2:0]  count;

   int n_checks = 0;
   int n_fail   = 0;

   fetch_inst_queue #(.p_seq_num_bits(5), .p_depth(4)) dut (
      .clk(clk), .rst(rst),
      .in_val(in_val), .in_rdy(in_rdy), .in_inst(in_inst), .in_pc(in_pc),
      .in_seq_num(in_seq_num),
      .out_val(out_val), .out_rdy(out_rdy), .out_inst(out_inst), .out_pc(out_pc),
      .out_seq_num(out_seq_num),
      .squash_val(squash_val), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic [31:0] pc;
      logic [31:0] inst;
      logic [4:0]  seq;
      logic        ordy;
      logic        sq;
      logic        e_irdy;
      logic        e_oval;
      int          e_cnt;
      logic        chk_d;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
      logic [4:0]  e_seq;
   } vec_t;

   vec_t vecs[$];

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [4:0]  seq;
   } ent_t;

   ent_t model[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                      input logic [4:0] seq, input logic ordy, input logic sq,
                      input logic e_irdy, input logic e_oval, input int e_cnt,
                      input logic chk_d, input logic [31:0] e_pc,
                      input logic [31:0] e_inst, input logic [4:0] e_seq);
      vec_t v;
      v.iv = iv; v.pc = pc; v.inst = inst; v.seq = seq; v.ordy = ordy; v.sq = sq;
      v.e_irdy = e_irdy; v.e_oval = e_oval; v.e_cnt = e_cnt; v.chk_d = chk_d;
      v.e_pc = e_pc; v.e_inst = e_inst; v.e_seq = e_seq;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                        input logic [4:0] seq, input logic ordy, input logic sq);
      @(negedge clk);
      in_val = iv; in_pc = pc; in_inst = inst; in_seq_num = seq;
      out_rdy = ordy; squash_val = sq;
      #1;
   endtask

   task automatic chk_ctl(input string tag, input logic e_irdy, input logic e_oval, input int e_cnt);
      chk({tag, " in_rdy"},  32'(in_rdy),  32'(e_irdy));
      chk({tag, " out_val"}, 32'(out_val), 32'(e_oval));
      chk({tag, " count"},   32'(count),   32'(e_cnt));
   endtask

   initial begin
      rst = 1'b1; in_val = 0; in_pc = 0; in_inst = 0; in_seq_num = 0;
      out_rdy = 0; squash_val = 0;

      // iv  pc       inst     seq ordy sq | irdy oval cnt chk pc       inst     seq
      add(1, 32'h200, 32'hA0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
      add(1, 32'h204, 32'hA1, 1, 0, 0,  1, 1, 1, 1, 32'h200, 32'hA0, 0);
      add(1, 32'h208, 32'hA2, 2, 0, 0,  1, 1, 2, 1, 32'h200, 32'hA0, 0);
      add(0, 32'h0,   32'h0,  0, 1, 0,  1, 1, 3, 1, 32'h200, 32'hA0, 0);
      add(0, 32'h0,   32'h0,  0, 1, 0,  1, 1, 2, 1, 32'h204, 32'hA1, 1);
      add(0, 32'h0,   32'h0,  0, 1, 0,  1, 1, 1, 1, 32'h208, 32'hA2, 2);
      add(0, 32'h0,   32'h0,  0, 1, 0,  1, 0, 0, 0, 0, 0, 0);
      // fill to 4, then in_val+out_rdy on a full queue dequeues only
      add(1, 32'h100, 32'hB0, 3, 0, 0,  1, 0, 0, 0, 0, 0, 0);
      add(1, 32'h104, 32'hB1, 4, 0, 0,  1, 1, 1, 1, 32'h100, 32'hB0, 3);
      add(1, 32'h108, 32'hB2, 5, 0, 0,  1, 1, 2, 1, 32'h100, 32'hB0, 3);
      add(1, 32'h10C, 32'hB3, 6, 0, 0,  1, 1, 3, 1, 32'h100, 32'hB0, 3);
      add(1, 32'h110, 32'hB4, 7, 0, 0,  0, 1, 4, 1, 32'h100, 32'hB0, 3);
      add(1, 32'h110, 32'hB4, 7, 1, 0,  0, 1, 4, 1, 32'h100, 32'hB0, 3);
      add(0, 32'h0,   32'h0,  0, 0, 0,  1, 1, 3, 1, 32'h104, 32'hB1, 4);
      add(0, 32'h0,   32'h0,  0, 1, 0,  1, 1, 3, 1, 32'h104, 32'hB1, 4);
      add(0, 32'h0,   32'h0,  0, 1, 0,  1, 1, 2, 1, 32'h108, 32'hB2, 5);
      add(0, 32'h0,   32'h0,  0, 1, 0,  1, 1, 1, 1, 32'h10C, 32'hB3, 6);
      add(0, 32'h0,   32'h0,  0, 1, 0,  1, 0, 0, 0, 0, 0, 0);
      // squash with 3 held entries and concurrent in_val/out_rdy
      add(1, 32'h120, 32'hD0, 8, 0, 0,  1, 0, 0, 0, 0, 0, 0);
      add(1, 32'h124, 32'hD1, 9, 0, 0,  1, 1, 1, 1, 32'h120, 32'hD0, 8);
      add(1, 32'h128, 32'hD2, 10, 0, 0, 1, 1, 2, 1, 32'h120, 32'hD0, 8);
      add(1, 32'h12C, 32'hD3, 11, 1, 1, 0, 0, 3, 0, 0, 0, 0);
      add(0, 32'h0,   32'h0,  0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
      add(1, 32'h300, 32'hC0, 9, 0, 0,  1, 0, 0, 0, 0, 0, 0);
      add(0, 32'h0,   32'h0,  0, 1, 0,  1, 1, 1, 1, 32'h300, 32'hC0, 9);
      add(0, 32'h0,   32'h0,  0, 0, 0,  1, 0, 0, 0, 0, 0, 0);

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_ctl("reset", 1, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         drive(vecs[i].iv, vecs[i].pc, vecs[i].inst, vecs[i].seq, vecs[i].ordy, vecs[i].sq);
         chk_ctl(tag, vecs[i].e_irdy, vecs[i].e_oval, vecs[i].e_cnt);
         if (vecs[i].chk_d) begin
            chk({tag, " out_pc"},      out_pc,              vecs[i].e_pc);
            chk({tag, " out_inst"},    out_inst,            vecs[i].e_inst);
            chk({tag, " out_seq_num"}, 32'(out_seq_num),    32'(vecs[i].e_seq));
         end
      end

      // streaming through pointer wrap: steady-state count 1, 1-cycle latency
      for (int k = 0; k < 10; k++) begin
         drive(1, 32'h200 + 32'(4 * k), 32'hE0 + 32'(k), 5'(k), 1, 0);
         if (k == 0) begin
            chk_ctl("stream0", 1, 0, 0);
         end else begin
            chk_ctl($sformatf("stream%0d", k), 1, 1, 1);
            chk($sformatf("stream%0d out_pc", k), out_pc, 32'h200 + 32'(4 * (k - 1)));
         end
      end
      drive(0, 0, 0, 0, 1, 0);
      chk_ctl("stream_tail", 1, 1, 1);
      chk("stream_tail out_pc", out_pc, 32'h224);
      drive(0, 0, 0, 0, 0, 0);
      chk_ctl("stream_empty", 1, 0, 0);

      // reset mid-operation with two entries held
      drive(1, 32'h400, 32'h1, 1, 0, 0);
      drive(1, 32'h404, 32'h2, 2, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      chk_ctl("pre_rst", 1, 1, 2);
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      #1;
      chk_ctl("post_rst", 1, 0, 0);

      // random traffic against a reference FIFO
      model.delete();
      for (int c = 0; c < 10000; c++) begin
         logic        iv, ordy, sq, e_irdy, e_oval;
         logic [31:0] pc, inst;
         logic [4:0]  seq;
         iv   = 1'($urandom_range(0, 1));
         ordy = 1'($urandom_range(0, 1));
         sq   = ($urandom_range(0, 15) == 0);
         pc   = $urandom;
         inst = $urandom;
         seq  = 5'($urandom);
         drive(iv, pc, inst, seq, ordy, sq);
         e_irdy = (model.size() < 4) && !sq;
         e_oval = (model.size() > 0) && !sq;
         chk_ctl($sformatf("rnd%0d", c), e_irdy, e_oval, model.size());
         if (count > 3'd4) chk($sformatf("rnd%0d count_range", c), 32'(count), 32'd4);
         if (e_oval) begin
            chk($sformatf("rnd%0d out_pc", c),   out_pc,   model[0].pc);
            chk($sformatf("rnd%0d out_inst", c), out_inst, model[0].inst);
            chk($sformatf("rnd%0d out_seq", c),  32'(out_seq_num), 32'(model[0].seq));
         end
         if (sq) begin
            model.delete();
         end else begin
            ent_t e;
            if (e_oval && ordy) void'(model.pop_front());
            if (e_irdy && iv) begin
               e.pc = pc; e.inst = inst; e.seq = seq;
               model.push_back(e);
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
